// File: rtl/akuma_pkg.sv
// Shared types and constants for the Akuma character controller and the
// downstream sprite selector.
package akuma_pkg;

    // Controller states
    typedef enum logic [1:0] {
        STAND = 2'd0,
        PUNCH = 2'd1,
        JUMP  = 2'd2
    } akuma_state_t;

    // Pose codes understood by the sprite selector
    localparam logic [2:0] SPR_STAND = 3'd0;
    localparam logic [2:0] SPR_PUNCH = 3'd1;
    localparam logic [2:0] SPR_JUMP  = 3'd2;

    // Map a controller state onto the pose code drawn for it
    function automatic logic [2:0] sprite_of(input akuma_state_t s);
        logic [2:0] spr;
        case (s)
            PUNCH:   spr = SPR_PUNCH;
            JUMP:    spr = SPR_JUMP;
            default: spr = SPR_STAND;
        endcase
        return spr;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vertical sync: produces a one-cycle frame tick.
// A vs level held high for many cycles yields a single tick.
module frame_tick_gen (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic vs,
    output logic frame_tick
);

    logic vs_q;

    // Delay vs by one cycle so the rising edge can be detected
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs;
        end
    end

    assign frame_tick = vs & ~vs_q;

endmodule

// File: rtl/akuma_motion_ctrl.sv
// Per-frame character controller for Akuma: stand/punch/jump state machine,
// horizontal movement with clamping and vertical jump physics. All state
// changes happen on the frame tick, so position and pose only change at
// frame boundaries.
// Optional feature: define AKUMA_AIR_STEER_EN to allow left/right movement
// while airborne (including the landing tick). Without it X is frozen in JUMP.
module akuma_motion_ctrl
    import akuma_pkg::*;
#(
    parameter logic [9:0] X_START      = 10'd120,
    parameter logic [9:0] X_MIN        = 10'd0,
    parameter logic [9:0] X_MAX        = 10'd560,
    parameter logic [9:0] GROUND_Y     = 10'd400,
    parameter logic [9:0] STEP_X       = 10'd4,
    parameter logic [5:0] JUMP_V       = 6'd12,
    parameter logic [5:0] GRAVITY      = 6'd1,
    parameter logic [4:0] PUNCH_FRAMES = 5'd8
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vs,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_punch,
    output logic [9:0] AkumaX,
    output logic [9:0] AkumaY,
    output logic [2:0] sprite,
    output logic       frame_tick
);

    akuma_state_t      state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic signed [6:0] vel_q, vel_d;
    logic [4:0]        pcnt_q, pcnt_d;
    logic [2:0]        sprite_q;

    logic              tick;

    // Horizontal movement helpers (11-bit signed so stepping never wraps)
    logic signed [10:0] x_left;
    logic signed [10:0] x_right;
    logic [9:0]         x_move;

    // Vertical physics helpers
    logic signed [6:0]  jump_vel;
    logic signed [10:0] ny;
    logic signed [7:0]  vel_sum;
    logic signed [6:0]  vel_next;

    frame_tick_gen u_tick (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .vs         (vs),
        .frame_tick (tick)
    );

    assign frame_tick = tick;
    assign jump_vel   = -$signed({1'b0, JUMP_V});

    // Candidate X after this frame's button request, clamped to the play field
    always_comb begin
        x_left  = $signed({1'b0, x_q}) - $signed({1'b0, STEP_X});
        x_right = $signed({1'b0, x_q}) + $signed({1'b0, STEP_X});
        x_move  = x_q;
        if (btn_left && !btn_right) begin
            if (x_left < $signed({1'b0, X_MIN})) begin
                x_move = X_MIN;
            end else begin
                x_move = x_left[9:0];
            end
        end else if (btn_right && !btn_left) begin
            if (x_right > $signed({1'b0, X_MAX})) begin
                x_move = X_MAX;
            end else begin
                x_move = x_right[9:0];
            end
        end
    end

    // Candidate Y and speed for an airborne frame; speed saturates at +63
    always_comb begin
        ny      = $signed({1'b0, y_q}) + $signed({{4{vel_q[6]}}, vel_q});
        vel_sum = $signed({vel_q[6], vel_q}) + $signed({2'b00, GRAVITY});
        if (vel_sum > 8'sd63) begin
            vel_next = 7'sd63;
        end else begin
            vel_next = vel_sum[6:0];
        end
    end

    // Next-state logic: nothing moves except on a frame tick
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vel_d   = vel_q;
        pcnt_d  = pcnt_q;
        if (tick) begin
            case (state_q)
                STAND: begin
                    x_d = x_move;
                    if (btn_jump) begin
                        // Lift-off: speed is set now, Y starts moving next tick
                        state_d = JUMP;
                        vel_d   = jump_vel;
                    end else if (btn_punch) begin
                        state_d = PUNCH;
                        pcnt_d  = PUNCH_FRAMES - 5'd1;
                    end
                end
                PUNCH: begin
                    if (pcnt_q == 5'd0) begin
                        state_d = STAND;
                    end else begin
                        pcnt_d = pcnt_q - 5'd1;
                    end
                end
                JUMP: begin
`ifdef AKUMA_AIR_STEER_EN
                    x_d = x_move;
`endif
                    // Only a descending jump can land
                    if ((vel_q > 7'sd0) && (ny >= $signed({1'b0, GROUND_Y}))) begin
                        y_d     = GROUND_Y;
                        vel_d   = 7'sd0;
                        state_d = STAND;
                    end else begin
                        y_d   = ny[9:0];
                        vel_d = vel_next;
                    end
                end
                default: begin
                    state_d = STAND;
                end
            endcase
        end
    end

    // State, position and registered pose code
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= STAND;
            x_q      <= X_START;
            y_q      <= GROUND_Y;
            vel_q    <= 7'sd0;
            pcnt_q   <= 5'd0;
            sprite_q <= SPR_STAND;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            pcnt_q   <= pcnt_d;
            sprite_q <= sprite_of(state_d);
        end
    end

    assign AkumaX = x_q;
    assign AkumaY = y_q;
    assign sprite = sprite_q;

endmodule

// File: tb/tb_akuma_motion_ctrl.sv
// Testbench for akuma_motion_ctrl: frames are issued with randomised vs
// timing and button noise between ticks; a per-frame behavioural model
// predicts the pose/position, and a monitor checks the DUT after each tick.
module tb_akuma_motion_ctrl;

    localparam int XS = 120, XMIN = 0, XMAX = 560, GY = 400, STEP = 4;
    localparam int JV = 12, GRAV = 1, PF = 8;

    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       vs = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, btn_punch = 1'b0;
    logic [9:0] AkumaX, AkumaY;
    logic [2:0] sprite;
    logic       frame_tick;

    akuma_motion_ctrl dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .vs         (vs),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_jump   (btn_jump),
        .btn_punch  (btn_punch),
        .AkumaX     (AkumaX),
        .AkumaY     (AkumaY),
        .sprite     (sprite),
        .frame_tick (frame_tick)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int x;
        int y;
        int spr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames_issued = 0;
    int   ticks_seen = 0;
    int   obs_min_y = 1000;

    // Behavioural reference: pose name, position, speed and punch frames left
    string m_pose;
    int    m_x, m_y, m_vel, m_left_frames, m_min_y;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_reset();
        m_pose = "stand"; m_x = XS; m_y = GY; m_vel = 0; m_left_frames = 0;
    endfunction

    function automatic int model_walk(input bit l, input bit r);
        if (l && !r) return clampi(m_x - STEP, XMIN, XMAX);
        if (r && !l) return clampi(m_x + STEP, XMIN, XMAX);
        return m_x;
    endfunction

    // One frame of the character's rules, in plain integer arithmetic
    function automatic void model_frame(input bit l, input bit r, input bit j, input bit p);
        if (m_pose == "stand") begin
            m_x = model_walk(l, r);
            if (j) begin
                m_pose = "jump"; m_vel = -JV;
            end else if (p) begin
                m_pose = "punch"; m_left_frames = PF - 1;
            end
        end else if (m_pose == "punch") begin
            if (m_left_frames == 0) m_pose = "stand";
            else m_left_frames--;
        end else begin
`ifdef AKUMA_AIR_STEER_EN
            m_x = model_walk(l, r);
`endif
            if (m_vel > 0 && m_y + m_vel >= GY) begin
                m_y = GY; m_vel = 0; m_pose = "stand";
            end else begin
                m_y = m_y + m_vel;
                m_vel = (m_vel + GRAV > 63) ? 63 : m_vel + GRAV;
            end
        end
        if (m_y < m_min_y) m_min_y = m_y;
    endfunction

    function automatic int model_sprite();
        if (m_pose == "punch") return 1;
        if (m_pose == "jump") return 2;
        return 0;
    endfunction

    // Issue one frame: buttons are valid only in the tick cycle, noise otherwise
    task automatic do_frame(input bit l, input bit r, input bit j, input bit p);
        exp_t e;
        @(posedge vga_clk); #1;
        btn_left = l; btn_right = r; btn_jump = j; btn_punch = p;
        vs = 1'b1;
        model_frame(l, r, j, p);
        e.x = m_x; e.y = m_y; e.spr = model_sprite();
        exp_q.push_back(e);
        frames_issued++;
        @(posedge vga_clk); #1;
        btn_left = 1'($urandom); btn_right = 1'($urandom);
        btn_jump = 1'($urandom); btn_punch = 1'($urandom);
        repeat ($urandom_range(0, 3)) @(posedge vga_clk);
        #1 vs = 1'b0;
        repeat ($urandom_range(2, 4)) @(posedge vga_clk);
        #1;
        btn_left = 0; btn_right = 0; btn_jump = 0; btn_punch = 0;
    endtask

    // Monitor: after each tick the new outputs are compared with the oldest prediction
    bit pending = 1'b0;
    always @(negedge vga_clk) begin
        if (pending) begin
            pending = 1'b0;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got tick with no prediction, expected none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tick_x", int'(AkumaX), e.x);
                check("tick_y", int'(AkumaY), e.y);
                check("tick_sprite", int'(sprite), e.spr);
                if (int'(AkumaY) < obs_min_y) obs_min_y = int'(AkumaY);
            end
        end
        if (frame_tick && reset_n) begin
            pending = 1'b1;
            ticks_seen++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cycles;
        model_reset();
        m_min_y = GY;

        // Reset state
        repeat (3) @(posedge vga_clk);
        #2;
        check("reset_x", int'(AkumaX), XS);
        check("reset_y", int'(AkumaY), GY);
        check("reset_sprite", int'(sprite), 0);
        check("reset_tick", int'(frame_tick), 0);
        @(posedge vga_clk); #1 reset_n = 1'b1;

        // Idle frames
        repeat (3) do_frame(0, 0, 0, 0);

        // Right clamp, then left clamp
        repeat (200) do_frame(0, 1, 0, 0);
        repeat (200) do_frame(1, 0, 0, 0);
        repeat (30) do_frame(0, 1, 0, 0);

        // Jump and punch together: jump wins, full arc
        m_min_y = GY;
        do_frame(0, 0, 1, 1);
        obs_min_y = 1000;
        repeat (25) do_frame(0, 0, 0, 0);
        @(posedge vga_clk); @(posedge vga_clk);
        check("jump_apex", obs_min_y, m_min_y);
        check("jump_apex_abs", obs_min_y, 322);

        // Punch pulse with right held afterwards
        do_frame(0, 0, 0, 1);
        repeat (10) do_frame(0, 1, 0, 0);

        // Jump while steering right
        do_frame(0, 0, 1, 0);
        repeat (26) do_frame(0, 1, 0, 0);

        // Reset at jump apex
        do_frame(0, 0, 1, 0);
        repeat (12) do_frame(0, 0, 0, 0);
        repeat (2) @(posedge vga_clk);
        check("apex_before_reset", int'(AkumaY), 322);
        #3 reset_n = 1'b0;
        #1;
        check("midreset_x", int'(AkumaX), XS);
        check("midreset_y", int'(AkumaY), GY);
        check("midreset_sprite", int'(sprite), 0);
        check("midreset_queue", exp_q.size(), 0);
        model_reset();
        repeat (3) @(posedge vga_clk);
        #1 reset_n = 1'b1;
        do_frame(0, 0, 0, 0);
        do_frame(0, 1, 0, 0);

        // Random play
        for (int i = 0; i < 300; i++) begin
            do_frame(1'($urandom), 1'($urandom),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end

        // Drain scoreboard
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 20) begin
            @(posedge vga_clk);
            wait_cycles++;
        end
        @(posedge vga_clk); @(posedge vga_clk);
        check("drain_queue", exp_q.size(), 0);
        check("tick_count", ticks_seen, frames_issued);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/akuma_motion_ctrl.md
# akuma_motion_ctrl

Per-frame character controller for Akuma. Samples player button levels once per video frame and runs the stand/punch/jump state machine. Integrates horizontal position and vertical jump physics. Drives the `AkumaX`, `AkumaY` and `sprite` inputs of the Akuma sprite selector directly downstream, so the drawn pose and position change only at frame boundaries.

## Interface
Parameters:
- `X_START`, 10'd120, reset X position
- `X_MIN`, 10'd0, left clamp
- `X_MAX`, 10'd560, right clamp
- `GROUND_Y`, 10'd400, standing Y; reset Y
- `STEP_X`, 10'd4, pixels moved per frame
- `JUMP_V`, 6'd12, initial upward speed in px/frame
- `GRAVITY`, 6'd1, speed added per frame
- `PUNCH_FRAMES`, 5'd8, punch duration in frames (≥1)

Ports:
- `vga_clk` in 1: single clock
- `reset_n` in 1: asynchronous, active-low reset
- `vs` in 1: vertical sync in the `vga_clk` domain; a rising edge marks a new frame
- `btn_left`, `btn_right`, `btn_jump`, `btn_punch` in 1 each: level inputs, active-high
- `AkumaX`, `AkumaY` out 10: sprite top-left position, registered
- `sprite` out 3: pose code (0 standing, 1 punching, 2 jumping), registered
- `frame_tick` out 1: one-cycle pulse, for debug and for the hitbox stage

## Operation
- Frame tick: `frame_tick = vs & ~vs_q`, where `vs_q` is `vs` registered. All state updates occur only on a tick cycle.
- States are STAND, PUNCH and JUMP. `sprite` is 0 in STAND, 1 in PUNCH and 2 in JUMP.
- STAND, on tick:
  - If `btn_jump` is high: go to JUMP and set `vel = -JUMP_V`. Y is unchanged this tick.
  - Else if `btn_punch` is high: go to PUNCH and set `pcnt = PUNCH_FRAMES-1`.
  - Jump has priority over punch.
  - Horizontal movement is applied on the same tick as the transition.
- PUNCH, on tick:
  - No horizontal movement. Buttons are ignored.
  - If `pcnt == 0`, go to STAND. Otherwise decrement `pcnt`.
- JUMP, on tick:
  - Compute `ny = Y + vel` in 11-bit signed arithmetic.
  - If `vel > 0` and `ny >= GROUND_Y`: set Y = GROUND_Y, vel = 0, go to STAND.
  - Otherwise set Y = `ny` and `vel = vel + GRAVITY`. `vel` is 7-bit signed and saturates at +63.
  - `btn_punch` is ignored.
- Horizontal movement (STAND, and JUMP if configured):
  - Left only: X = max(X − STEP_X, X_MIN). Compute in 11-bit signed so there is no underflow wrap.
  - Right only: X = min(X + STEP_X, X_MAX).
  - Both or neither pressed: X is held.
- With default parameters a jump occupies exactly 25 JUMP ticks, reaching apex Y = 322.

## Timing
- Reset, asynchronous: AkumaX = X_START, AkumaY = GROUND_Y, sprite = 0, state STAND, vel = 0, pcnt = 0, `vs_q` = 0, so `frame_tick` = 0 while `vs` is low.
- Reset asserted mid-jump or mid-punch returns all of the above immediately. The first frame after release behaves as STAND.
- Outputs update on the `vga_clk` edge ending the tick cycle, which is 1 cycle after the `vs` rise is visible on the input.
- Outputs are stable for the entire frame between ticks.
- Buttons are sampled only in the tick cycle. Pulses shorter than that and not overlapping it are lost, by design.
- `vs` held high for many cycles produces exactly one tick.

## Configuration
- `AKUMA_AIR_STEER_EN` defined: the horizontal movement rules also apply in JUMP ticks, including the tick that lands.
- Not defined: X is frozen for the whole of JUMP.

## Structure
- Package `akuma_pkg` holds:
  - state enum `akuma_state_t` (STAND, PUNCH, JUMP)
  - sprite codes `SPR_STAND = 3'd0`, `SPR_PUNCH = 3'd1`, `SPR_JUMP = 3'd2`, shared with the sprite selector
- Sub-module `frame_tick_gen` holds the `vs` edge detector: `vga_clk`, `reset_n`, `vs` → `frame_tick`.

## Test plan
- Reset release, then 3 ticks with no buttons → AkumaX = 120, AkumaY = 400, sprite = 0 throughout.
- `btn_right` held for 200 ticks → X increases by 4 per tick and clamps at 560. `btn_left` held for 200 ticks → X clamps at 0 with no wrap.
- `btn_jump` + `btn_punch` pressed together at one tick → sprite = 2. Min Y = 322. Y = 400 and sprite = 0 after 25 further ticks.
- `btn_punch` pulse for one tick → sprite = 1 for exactly 8 ticks, X frozen even with `btn_right` held, then sprite = 0.
- Jump with `btn_right` held → X += 100 over the 25 JUMP ticks with `AKUMA_AIR_STEER_EN` defined; X unchanged without it.
- `reset_n` pulsed low at jump apex → immediately Y = 400, sprite = 0, X = 120. The next tick with no buttons keeps STAND.
